// File: rtl/uart_dram_loader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_dram_loader_pkg                                                    |
// | Shared DRAMCON request codes, default sizes and loader state encodings. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package uart_dram_loader_pkg;

    localparam logic [1:0] DRAM_REQ_IDLE  = 2'd0;
    localparam logic [1:0] DRAM_REQ_WRITE = 2'd2;

    // Bits per DRAMCON address unit.
    localparam int D_VS              = 8;
    localparam int SERIAL_WCNT_DEF   = 100;
    localparam int APPDATA_WIDTH_DEF = 512;
    localparam int SORT_ELM          = 65536;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_JUDGE   = 3'd1,
        W_REQ     = 3'd2,
        W_WRITING = 3'd3,
        W_FIN     = 3'd4
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_dram_loader_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_rx                                                                 |
// | 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, frame check.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module uart_rx
    import uart_dram_loader_pkg::*;
#(
    parameter int SERIAL_WCNT = SERIAL_WCNT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o
);
    localparam int             CW        = $clog2(SERIAL_WCNT);
    localparam logic [CW-1:0]  HALF_LAST = CW'(SERIAL_WCNT / 2 - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(SERIAL_WCNT - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is already high again at mid-bit was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {sync2_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o  = sh_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_dram_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_dram_loader                                                        |
// | UART bytes -> packed lines -> line FIFO -> DRAMCON burst writes.        |
// | Optional running element checksum: define LOADER_CHECKSUM_EN.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module uart_dram_loader
    import uart_dram_loader_pkg::*;
#(
    parameter int SERIAL_WCNT   = SERIAL_WCNT_DEF,
    parameter int APPDATA_WIDTH = APPDATA_WIDTH_DEF,
    parameter int ELM_TOTAL     = SORT_ELM,
    parameter int WBLOCKS       = 4,
    parameter int FIFO_LOG      = 3
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic                     RXD,
    input  logic                     d_busy,
    input  logic                     d_w,
    output logic [1:0]               d_req,
    output logic [31:0]              d_initadr,
    output logic [31:0]              d_blocks,
    output logic [APPDATA_WIDTH-1:0] d_din,
    output logic                     done,
    output logic                     rx_err,
    output logic [31:0]              checksum
);
    localparam int                BPL         = APPDATA_WIDTH / 8;
    localparam int                BCW         = $clog2(BPL);
    localparam int                DEPTH       = 1 << FIFO_LOG;
    localparam int                WCW         = $clog2(WBLOCKS + 1);
    localparam logic [BCW-1:0]    LAST_BYTE   = BCW'(BPL - 1);
    localparam logic [FIFO_LOG:0] FIFO_FULL   = (FIFO_LOG + 1)'(DEPTH);
    localparam logic [FIFO_LOG:0] BURST_LINES = (FIFO_LOG + 1)'(WBLOCKS);
    localparam logic [WCW-1:0]    BURST_CNT   = WCW'(WBLOCKS);
    localparam logic [31:0]       LINES_TOTAL = 32'(ELM_TOTAL * 32 / APPDATA_WIDTH);
    localparam logic [31:0]       LINES_STEP  = 32'(WBLOCKS);
    localparam logic [31:0]       ADDR_STEP   = 32'(WBLOCKS * (APPDATA_WIDTH / D_VS));

    logic [7:0] w_rx_byte;
    logic       w_rx_valid, w_rx_ferr;

    uart_rx #(
        .SERIAL_WCNT (SERIAL_WCNT)
    ) u_rx (
        .clk_i   (CLK),
        .rst_ni  (RST_X),
        .rxd_i   (RXD),
        .byte_o  (w_rx_byte),
        .valid_o (w_rx_valid),
        .ferr_o  (w_rx_ferr)
    );

    wr_state_t state_q, state_d;
    logic      w_fin, w_take;
    assign w_fin  = (state_q == W_FIN);
    assign w_take = w_rx_valid && !w_fin;

    // ---------------- byte packing ----------------
    logic [APPDATA_WIDTH-1:0] pack_q, pack_d, w_line;
    logic [BCW-1:0]           bcnt_q, bcnt_d;
    logic                     w_enq;

    always_comb begin
        pack_d = pack_q;
        bcnt_d = bcnt_q;
        w_line = pack_q;
        w_enq  = 1'b0;
        if (w_take) begin
            w_line[8*bcnt_q +: 8] = w_rx_byte;
            if (bcnt_q == LAST_BYTE) begin
                w_enq  = 1'b1;
                pack_d = '0;
                bcnt_d = '0;
            end else begin
                pack_d = w_line;
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // ---------------- line FIFO ----------------
    logic [APPDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_LOG-1:0]      wp_q, rp_q;
    logic [FIFO_LOG:0]        fcnt_q;
    logic                     w_full, w_empty, w_push, w_pop;

    assign w_full  = (fcnt_q == FIFO_FULL);
    assign w_empty = (fcnt_q == '0);
    assign w_push  = w_enq && !w_full;
    assign w_pop   = d_w && !w_empty;
    assign d_din   = w_empty ? '0 : mem_q[rp_q];

    always_ff @(posedge CLK) begin
        if (w_push) mem_q[wp_q] <= w_line;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            pack_q <= '0;
            bcnt_q <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            pack_q <= pack_d;
            bcnt_q <= bcnt_d;
            if (w_push) wp_q <= wp_q + 1'b1;
            if (w_pop)  rp_q <= rp_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // ---------------- write request FSM ----------------
    logic [31:0]    waddr_q, waddr_d, lines_q, lines_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [1:0]     req_q, req_d;
    logic [31:0]    adr_q, adr_d, blk_q, blk_d;
    logic           done_q, done_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        lines_d = lines_q;
        wcnt_d  = wcnt_q;
        req_d   = DRAM_REQ_IDLE;
        adr_d   = adr_q;
        blk_d   = blk_q;
        done_d  = done_q;
        err_d   = err_q | (w_rx_ferr && !w_fin) | (w_enq && w_full);
        case (state_q)
            W_IDLE: begin
                if (fcnt_q >= BURST_LINES && lines_q < LINES_TOTAL) state_d = W_JUDGE;
            end
            W_JUDGE: begin
                if (!d_busy) state_d = W_REQ;
            end
            W_REQ: begin
                // The request is held for exactly one cycle, then the burst begins.
                if (req_q != DRAM_REQ_IDLE) begin
                    state_d = W_WRITING;
                    wcnt_d  = '0;
                end else if (!d_busy) begin
                    req_d = DRAM_REQ_WRITE;
                    adr_d = waddr_q;
                    blk_d = LINES_STEP;
                end
            end
            W_WRITING: begin
                if (w_pop && wcnt_q != BURST_CNT) wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q == BURST_CNT && !d_busy) begin
                    waddr_d = waddr_q + ADDR_STEP;
                    lines_d = lines_q + LINES_STEP;
                    state_d = (lines_q + LINES_STEP == LINES_TOTAL) ? W_FIN : W_IDLE;
                end
            end
            W_FIN: begin
                if (!d_busy) done_d = 1'b1;
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= W_IDLE;
            waddr_q <= '0;
            lines_q <= '0;
            wcnt_q  <= '0;
            req_q   <= DRAM_REQ_IDLE;
            adr_q   <= '0;
            blk_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            lines_q <= lines_d;
            wcnt_q  <= wcnt_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            blk_q   <= blk_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign d_req     = req_q;
    assign d_initadr = adr_q;
    assign d_blocks  = blk_q;
    assign done      = done_q;
    assign rx_err    = err_q;

`ifdef LOADER_CHECKSUM_EN
    // Summed on the 4th byte of every element, including lines later dropped.
    logic [31:0] chk_q;
    logic [31:0] w_elem;
    assign w_elem = w_line[32*(int'(bcnt_q) / 4) +: 32];

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            chk_q <= '0;
        end else if (w_take && bcnt_q[1:0] == 2'b11) begin
            chk_q <= chk_q + w_elem;
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = 32'd0;
`endif

endmodule
`default_nettype wire
